alu_result_fifo: RTL and testbench

Downstream capture stage for the 4-bit ALU. Each accepted ALU result (4-bit out, carry/zero/sign/parity/overflow flags, and the 2-bit select that produced it) is pushed into a DEPTH-entry FIFO. Results are presented to the consumer (register file / display logic) through a valid/ready handshake. Optional sticky carry/overflow status accumulates across results.

---
 rtl/alu_result_fifo.sv | 125 ++++++++++++
 tb/tb_alu_result_fifo.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_result_fifo.sv
// -----------------------------------------------------------------------------
// alu_result_fifo
//
// Capture stage behind the 4-bit ALU. Each accepted ALU result, together with
// its flags and the select code that produced it, is stored as one 11-bit
// entry in a DEPTH-entry FIFO. The consumer reads the head entry through a
// valid/ready handshake with first-word fall-through.
//
// Optional feature macro: ALU_STICKY_FLAGS_EN
//   defined   -> sticky carry/overflow registers accumulate over every push
//   undefined -> sticky outputs are tied to 0 and sticky_clear is ignored
//
// Ports
//   clk, rst                 rising-edge clock, async active-high reset
//   in_valid / in_ready      producer handshake (in_ready = !full)
//   alu_out, alu_carry, alu_zero, alu_sign, alu_parity, alu_overflow,
//   alu_select               ALU result fields captured on push
//   res_valid / res_ready    consumer handshake (res_valid = !empty)
//   res_out, res_carry, res_zero, res_sign, res_parity, res_overflow,
//   res_select               head entry fields
//   count                    occupied entries, 0..DEPTH
//   full, empty              occupancy status
//   sticky_clear             synchronous clear of sticky flags
//   sticky_carry, sticky_overflow  accumulated flags
// -----------------------------------------------------------------------------
module alu_result_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [3:0]                 alu_out,
  input  logic                       alu_carry,
  input  logic                       alu_zero,
  input  logic                       alu_sign,
  input  logic                       alu_parity,
  input  logic                       alu_overflow,
  input  logic [1:0]                 alu_select,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [3:0]                 res_out,
  output logic                       res_carry,
  output logic                       res_zero,
  output logic                       res_sign,
  output logic                       res_parity,
  output logic                       res_overflow,
  output logic [1:0]                 res_select,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty,
  input  logic                       sticky_clear,
  output logic                       sticky_carry,
  output logic                       sticky_overflow
);

  localparam int AW = $clog2(DEPTH);  // address bits
  localparam int PW = AW + 1;         // pointer bits incl. wrap bit

  typedef logic [10:0] entry_t;

  entry_t        mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  entry_t        wr_entry;
  logic          push;
  logic          pop;

  assign wr_entry = {alu_select, alu_overflow, alu_parity, alu_sign,
                     alu_zero, alu_carry, alu_out};

  // Same address with opposite wrap bits means the writer is a full lap ahead.
  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign empty = (wr_ptr == rd_ptr);
  assign count = wr_ptr - rd_ptr;

  // in_ready depends only on registered state, so a pop never opens a slot
  // for a push in the same cycle while full.
  assign in_ready  = !full;
  assign res_valid = !empty;
  assign push      = in_valid & in_ready;
  assign pop       = res_valid & res_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: storage is reset as well so res_* read 0 straight out of reset;
      // a plain data RAM would normally be left unreset.
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr[AW-1:0]] <= wr_entry;
        wr_ptr              <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // First-word fall-through: head entry is read combinationally.
  assign {res_select, res_overflow, res_parity, res_sign,
          res_zero, res_carry, res_out} = mem[rd_ptr[AW-1:0]];

`ifdef ALU_STICKY_FLAGS_EN
  // A flagged push in the same cycle as sticky_clear leaves the flag set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sticky_carry    <= 1'b0;
      sticky_overflow <= 1'b0;
    end else if (sticky_clear) begin
      sticky_carry    <= push & alu_carry;
      sticky_overflow <= push & alu_overflow;
    end else if (push) begin
      sticky_carry    <= sticky_carry    | alu_carry;
      sticky_overflow <= sticky_overflow | alu_overflow;
    end
  end
`else
  logic unused_sticky_clear;
  assign unused_sticky_clear = sticky_clear;
  assign sticky_carry        = 1'b0;
  assign sticky_overflow     = 1'b0;
`endif

endmodule

// File: tb/tb_alu_result_fifo.sv
module tb_alu_result_fifo;

  localparam int DEPTH = 4;
`ifdef ALU_STICKY_FLAGS_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready;
  logic [3:0] alu_out;
  logic       alu_carry, alu_zero, alu_sign, alu_parity, alu_overflow;
  logic [1:0] alu_select;
  logic       res_valid, res_ready;
  logic [3:0] res_out;
  logic       res_carry, res_zero, res_sign, res_parity, res_overflow;
  logic [1:0] res_select;
  logic [2:0] count;
  logic       full, empty;
  logic       sticky_clear, sticky_carry, sticky_overflow;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alu_result_fifo #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .alu_out(alu_out), .alu_carry(alu_carry), .alu_zero(alu_zero),
    .alu_sign(alu_sign), .alu_parity(alu_parity), .alu_overflow(alu_overflow),
    .alu_select(alu_select),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_out(res_out), .res_carry(res_carry), .res_zero(res_zero),
    .res_sign(res_sign), .res_parity(res_parity), .res_overflow(res_overflow),
    .res_select(res_select),
    .count(count), .full(full), .empty(empty),
    .sticky_clear(sticky_clear), .sticky_carry(sticky_carry),
    .sticky_overflow(sticky_overflow)
  );

  typedef struct {
    logic        iv;
    logic        rr;
    logic [10:0] d;
    logic [2:0]  cnt;
    logic        vld;
    logic        fl;
    logic [10:0] head;
    logic        sc;
    logic        so;
  } vec_t;

  vec_t vecs[11];

  // {select, overflow, parity, sign, zero, carry, out}
  function automatic logic [10:0] mk(input logic [1:0] sel, input logic ov,
                                     input logic par, input logic sg,
                                     input logic z, input logic c,
                                     input logic [3:0] o);
    return {sel, ov, par, sg, z, c, o};
  endfunction

  function automatic logic [10:0] head_entry();
    return {res_select, res_overflow, res_parity, res_sign,
            res_zero, res_carry, res_out};
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic iv, input logic rr, input logic [10:0] d,
                       input logic clr);
    in_valid     = iv;
    res_ready    = rr;
    {alu_select, alu_overflow, alu_parity, alu_sign,
     alu_zero, alu_carry, alu_out} = d;
    sticky_clear = clr;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [10:0] q[$];
  logic [10:0] e;

  initial begin
    rst = 1'b1;
    drive(1'b0, 1'b0, 11'h0, 1'b0);

    vecs[0]  = '{1, 0, mk(0,0,0,0,0,1,4'h9), 3'd1, 1, 0, mk(0,0,0,0,0,1,4'h9), 1, 0};
    vecs[1]  = '{1, 0, mk(1,1,0,1,0,0,4'hA), 3'd2, 1, 0, mk(0,0,0,0,0,1,4'h9), 1, 1};
    vecs[2]  = '{1, 0, mk(2,0,1,0,1,0,4'hB), 3'd3, 1, 0, mk(0,0,0,0,0,1,4'h9), 1, 1};
    vecs[3]  = '{1, 0, mk(3,1,1,1,1,1,4'hC), 3'd4, 1, 1, mk(0,0,0,0,0,1,4'h9), 1, 1};
    vecs[4]  = '{1, 0, mk(0,0,0,0,0,0,4'hD), 3'd4, 1, 1, mk(0,0,0,0,0,1,4'h9), 1, 1};
    vecs[5]  = '{1, 1, mk(1,0,0,0,0,1,4'hE), 3'd3, 1, 0, mk(1,1,0,1,0,0,4'hA), 1, 1};
    vecs[6]  = '{0, 1, 11'h0,                 3'd2, 1, 0, mk(2,0,1,0,1,0,4'hB), 1, 1};
    vecs[7]  = '{0, 1, 11'h0,                 3'd1, 1, 0, mk(3,1,1,1,1,1,4'hC), 1, 1};
    vecs[8]  = '{0, 1, 11'h0,                 3'd0, 0, 0, 11'h0,                1, 1};
    vecs[9]  = '{0, 1, 11'h0,                 3'd0, 0, 0, 11'h0,                1, 1};
    vecs[10] = '{1, 1, mk(1,0,1,0,0,0,4'h5), 3'd1, 1, 0, mk(1,0,1,0,0,0,4'h5), 1, 1};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_count", 32'(count), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_head", 32'(head_entry()), 32'd0);
    check("rst_sticky", 32'({sticky_carry, sticky_overflow}), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Table: fill, drop when full, no pass-through on pop-while-full,
    // drain, pop while empty, push+pop while empty.
    for (int i = 0; i < 11; i++) begin
      drive(vecs[i].iv, vecs[i].rr, vecs[i].d, 1'b0);
      step();
      check($sformatf("v%0d_count", i), 32'(count), 32'(vecs[i].cnt));
      check($sformatf("v%0d_valid", i), 32'(res_valid), 32'(vecs[i].vld));
      check($sformatf("v%0d_empty", i), 32'(empty), 32'(!vecs[i].vld));
      check($sformatf("v%0d_full", i), 32'(full), 32'(vecs[i].fl));
      check($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'(!vecs[i].fl));
      if (vecs[i].vld)
        check($sformatf("v%0d_head", i), 32'(head_entry()), 32'(vecs[i].head));
      check($sformatf("v%0d_sticky_c", i), 32'(sticky_carry), 32'(STICKY & vecs[i].sc));
      check($sformatf("v%0d_sticky_o", i), 32'(sticky_overflow), 32'(STICKY & vecs[i].so));
    end

    // Sustained push+pop at count=2 across the pointer wrap
    q.push_back(vecs[10].d);
    e = mk(2,0,0,1,0,0,4'h6);
    drive(1'b1, 1'b0, e, 1'b0);
    q.push_back(e);
    step();
    check("wrap_pre_count", 32'(count), 32'd2);
    for (int i = 0; i < 10; i++) begin
      e = mk(2'(i), i[0], i[1], 1'b0, 1'b0, 1'b0, 4'(i + 7));
      drive(1'b1, 1'b1, e, 1'b0);
      step();
      void'(q.pop_front());
      q.push_back(e);
      check($sformatf("wrap%0d_count", i), 32'(count), 32'd2);
      check($sformatf("wrap%0d_head", i), 32'(head_entry()), 32'(q[0]));
    end

    // Sticky sequence from a fresh reset
    drive(1'b0, 1'b0, 11'h0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    drive(1'b1, 1'b0, mk(0,1,0,0,0,0,4'h1), 1'b0);
    step();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, mk(1,0,0,0,0,0,4'h2), 1'b0);
      step();
    end
    check("stk_count", 32'(count), 32'd4);
    check("stk_ov_held", 32'(sticky_overflow), 32'(STICKY));
    check("stk_c_clean", 32'(sticky_carry), 32'd0);
    // Dropped push while full must not touch sticky state
    drive(1'b1, 1'b0, mk(1,0,0,0,0,1,4'h3), 1'b0);
    step();
    check("stk_drop_c", 32'(sticky_carry), 32'd0);
    drive(1'b0, 1'b1, 11'h0, 1'b0);
    step();
    check("stk_pop_count", 32'(count), 32'd3);
    drive(1'b1, 1'b0, mk(1,0,0,0,0,1,4'h3), 1'b1);
    step();
    check("stk_clr_c", 32'(sticky_carry), 32'(STICKY));
    check("stk_clr_o", 32'(sticky_overflow), 32'd0);
    check("stk_clr_count", 32'(count), 32'd4);

    // Async reset between edges with count=3
    drive(1'b0, 1'b1, 11'h0, 1'b0);
    step();
    drive(1'b0, 1'b0, 11'h0, 1'b0);
    check("ar_pre_count", 32'(count), 32'd3);
    #2;
    rst = 1'b1;
    #1;
    check("ar_empty", 32'(empty), 32'd1);
    check("ar_valid", 32'(res_valid), 32'd0);
    check("ar_res_out", 32'(res_out), 32'd0);
    check("ar_count", 32'(count), 32'd0);
    check("ar_sticky", 32'({sticky_carry, sticky_overflow}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
